clause_bank: RTL and testbench
==============================

CLAUSE_BANK -- requirements
Module: clause_bank

Interface
REQ-001 SHALL have parameter NUM_CLAUSES, default 8, number of clause slots.
REQ-002 SHALL have parameter NUM_VARS, default 8, literals per clause.
REQ-003 SHALL have parameter WIDTH_C_LEN, default 4, clause-length width.
REQ-004 SHALL have ports: clk  in  1  single clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: wr_i  in  NUM_CLAUSES  one-hot direct write of an original clause; clause_i  in  NUM_VARS*2  literals; clause_len_i  in  WIDTH_C_LEN  length.
REQ-006 SHALL have ports: learnt_valid_i  in  1; learnt_ready_o  out  1  learnt-insert handshake using clause_i/clause_len_i.
REQ-007 SHALL have ports: rd_en_i  in  1; rd_idx_i  in  $clog2(NUM_CLAUSES); rd_valid_o  out  1; rd_clause_o  out  NUM_VARS*2; rd_len_o  out  WIDTH_C_LEN; rd_learnt_o  out  1.
REQ-008 SHALL have ports: clear_learnt_i  in  1  bulk learnt removal; learntc_insert_index_o  out  NUM_CLAUSES  one-hot next insert slot; insert_done_o  out  1; insert_slot_o  out  $clog2(NUM_CLAUSES); evicted_o  out  1; free_cnt_o  out  $clog2(NUM_CLAUSES+1); full_o  out  1.

Function
REQ-009 SHALL encode each literal in 2 bits: 0 absent, 1 positive, 2 negative, 3 reserved (stored, never interpreted).
REQ-010 SHALL treat a slot as empty iff its stored length is 0; each slot also holds a learnt flag.
REQ-011 SHALL, on a clock edge with wr_i[k]=1, store clause_i/clause_len_i into slot k and clear its learnt flag; wr_i with more than one bit set writes all flagged slots; length 0 empties the slot.
REQ-012 SHALL drive learntc_insert_index_o combinationally: lowest-index empty slot; otherwise first learnt slot at or after victim pointer vptr (wrapping mod NUM_CLAUSES); otherwise all zeros.
REQ-013 SHALL drive learnt_ready_o = state IDLE AND wr_i==0 AND learntc_insert_index_o!=0.
REQ-014 SHALL, on an edge with learnt_valid_i AND learnt_ready_o, write the selected slot with learnt flag 1; next cycle pulse insert_done_o for one cycle with insert_slot_o = slot and evicted_o = 1 iff the slot was occupied.
REQ-015 SHALL, on eviction, set vptr to (slot+1) mod NUM_CLAUSES; vptr SHALL be unchanged on inserts into empty slots.
REQ-016 SHALL accept a learnt insert with clause_len_i=0 as a handshake but write nothing and pulse no insert_done_o.
REQ-017 SHALL give wr_i priority over learnt inserts: learnt_ready_o low in any cycle with wr_i!=0.
REQ-018 SHALL return read data one cycle after rd_en_i (rd_valid_o high that cycle), read-old: same-edge writes are not visible; out-of-range rd_idx_i returns zeros with rd_valid_o high.
REQ-019 SHALL implement FSM IDLE/CLEAR: clear_learnt_i in IDLE enters CLEAR; CLEAR visits slots 0..NUM_CLAUSES-1 one per cycle, zeroing length and flag of learnt slots, then returns to IDLE and resets vptr to 0; clear_learnt_i during CLEAR is ignored.
REQ-020 SHALL accept wr_i during CLEAR; a write to a slot not yet visited is an original clause and is not cleared.
REQ-021 SHALL register free_cnt_o (number of empty slots) and full_o (free_cnt_o==0), both updated the cycle after the change.

Reset
REQ-022 SHALL, on rst high, asynchronously clear all literals, lengths, learnt flags, vptr=0, state IDLE, rd_valid_o=0, insert_done_o=0, evicted_o=0, insert_slot_o=0, rd outputs 0, free_cnt_o=NUM_CLAUSES, full_o=0.
REQ-023 SHALL abort CLEAR on reset mid-sweep; after release learnt_ready_o=1 and learntc_insert_index_o has bit 0 set.

Structure
REQ-024 SHALL place literal-encoding constants, the FSM state enum and the slot-record typedef (literals, length, learnt flag) in a shared package sat_pkg.
REQ-025 SHALL use one sub-module, slot_select, implementing the lowest-empty / round-robin-learnt selection of REQ-012.

Verification
REQ-026 SHALL cover: write five clauses lengths 2,3,3,3,3 into slots 0-4, slots 5-7 length 0 -> learntc_insert_index_o=00100000, free_cnt_o=3, full_o=0.
REQ-027 SHALL cover: then three learnt inserts -> insert_slot_o 5,6,7, evicted_o=0, full_o=1, index=00100000; fourth insert -> slot 5, evicted_o=1, vptr=6, index=01000000.
REQ-028 SHALL cover: clear_learnt_i pulse -> learnt_ready_o low 8 cycles, then free_cnt_o=3, index=00100000, rd of slot 5 returns length 0.
REQ-029 SHALL cover: all 8 slots written via wr_i (lengths 2,3,3,3,3,2,4,4) -> full_o=1, index=00000000, learnt_ready_o=0, learnt_valid_i held 3 cycles produces no insert_done_o.
REQ-030 SHALL cover: wr_i=00000001 and learnt_valid_i same cycle -> slot 0 written, learnt insert accepted next cycle only.
REQ-031 SHALL cover: rst asserted at cycle 3 of CLEAR -> all outputs at reset values immediately, free_cnt_o=8 after release.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types for the clause store: literal codes, FSM states and slot record.
package sat_pkg;

    localparam int SLOT_VARS  = 8;
    localparam int SLOT_LEN_W = 4;

    localparam logic [1:0] LIT_ABSENT = 2'd0;
    localparam logic [1:0] LIT_POS    = 2'd1;
    localparam logic [1:0] LIT_NEG    = 2'd2;
    localparam logic [1:0] LIT_RSVD   = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic [2*SLOT_VARS-1:0] lits;
        logic [SLOT_LEN_W-1:0]  len;
        logic                   learnt;
    } slot_t;

endpackage

// File: rtl/slot_select.sv
// Picks the next learnt-insert slot: lowest empty slot, else the first
// learnt slot at or after the victim pointer (wrapping).
module slot_select #(
    parameter int NUM_CLAUSES = 8
) (
    input  logic [NUM_CLAUSES-1:0]         empty,
    input  logic [NUM_CLAUSES-1:0]         learnt,
    input  logic [$clog2(NUM_CLAUSES)-1:0] vptr,
    output logic [NUM_CLAUSES-1:0]         sel
);

    logic found;
    int   j;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_CLAUSES; i++) begin
            if (!found && empty[i]) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int k = 0; k < NUM_CLAUSES; k++) begin
            j = int'(vptr) + k;
            if (j >= NUM_CLAUSES) j = j - NUM_CLAUSES;
            if (!found && learnt[j]) begin
                sel[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clause_bank.sv
// Clause storage with direct original writes, learnt inserts with
// round-robin eviction, a learnt-clearing sweep and registered reads.
module clause_bank
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_C_LEN = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CLAUSES-1:0]           wr_i,
    input  logic [NUM_VARS*2-1:0]            clause_i,
    input  logic [WIDTH_C_LEN-1:0]           clause_len_i,
    input  logic                             learnt_valid_i,
    output logic                             learnt_ready_o,
    input  logic                             rd_en_i,
    input  logic [$clog2(NUM_CLAUSES)-1:0]   rd_idx_i,
    output logic                             rd_valid_o,
    output logic [NUM_VARS*2-1:0]            rd_clause_o,
    output logic [WIDTH_C_LEN-1:0]           rd_len_o,
    output logic                             rd_learnt_o,
    input  logic                             clear_learnt_i,
    output logic [NUM_CLAUSES-1:0]           learntc_insert_index_o,
    output logic                             insert_done_o,
    output logic [$clog2(NUM_CLAUSES)-1:0]   insert_slot_o,
    output logic                             evicted_o,
    output logic [$clog2(NUM_CLAUSES+1)-1:0] free_cnt_o,
    output logic                             full_o
);

    localparam int IW = $clog2(NUM_CLAUSES);
    localparam int CW = $clog2(NUM_CLAUSES + 1);

    // Slot record widths come from sat_pkg; parameters must stay in step.
    slot_t            slots [NUM_CLAUSES];
    state_t           state;
    logic [IW-1:0]    vptr;
    logic [IW-1:0]    cl_idx;
    logic [IW-1:0]    ins_slot;
    logic [NUM_CLAUSES-1:0] empty;
    logic [NUM_CLAUSES-1:0] learnt;
    logic [CW-1:0]    free_now;
    logic             accept;
    logic             do_insert;
    logic             ins_occupied;

    always_comb begin
        free_now = '0;
        for (int i = 0; i < NUM_CLAUSES; i++) begin
            empty[i]  = (slots[i].len == '0);
            learnt[i] = slots[i].learnt;
            free_now  = free_now + CW'(empty[i]);
        end
    end

    slot_select #(
        .NUM_CLAUSES(NUM_CLAUSES)
    ) u_sel (
        .empty (empty),
        .learnt(learnt),
        .vptr  (vptr),
        .sel   (learntc_insert_index_o)
    );

    always_comb begin
        ins_slot = '0;
        for (int i = 0; i < NUM_CLAUSES; i++) begin
            if (learntc_insert_index_o[i]) ins_slot = IW'(i);
        end
    end

    assign learnt_ready_o = (state == ST_IDLE) && (wr_i == '0)
                         && (|learntc_insert_index_o);
    assign accept       = learnt_valid_i && learnt_ready_o;
    // Zero-length learnt clauses complete the handshake but store nothing.
    assign do_insert    = accept && (clause_len_i != '0);
    assign ins_occupied = (slots[ins_slot].len != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLAUSES; i++) slots[i] <= '0;
            state         <= ST_IDLE;
            vptr          <= '0;
            cl_idx        <= '0;
            insert_done_o <= 1'b0;
            insert_slot_o <= '0;
            evicted_o     <= 1'b0;
        end else begin
            insert_done_o <= do_insert;
            evicted_o     <= do_insert && ins_occupied;
            unique case (state)
                ST_IDLE: begin
                    if (clear_learnt_i) begin
                        state  <= ST_CLEAR;
                        cl_idx <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (slots[cl_idx].learnt) begin
                        slots[cl_idx].len    <= '0;
                        slots[cl_idx].learnt <= 1'b0;
                    end
                    if (cl_idx == IW'(NUM_CLAUSES - 1)) begin
                        state  <= ST_IDLE;
                        vptr   <= '0;
                        cl_idx <= '0;
                    end else begin
                        cl_idx <= cl_idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (do_insert) begin
                slots[ins_slot] <= '{lits: clause_i, len: clause_len_i,
                                     learnt: 1'b1};
                insert_slot_o   <= ins_slot;
                if (ins_occupied) begin
                    vptr <= (ins_slot == IW'(NUM_CLAUSES - 1))
                          ? '0 : ins_slot + 1'b1;
                end
            end
            // Direct writes come last so they win over a same-edge sweep.
            for (int k = 0; k < NUM_CLAUSES; k++) begin
                if (wr_i[k]) begin
                    slots[k] <= '{lits: clause_i, len: clause_len_i,
                                 learnt: 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_o  <= 1'b0;
            rd_clause_o <= '0;
            rd_len_o    <= '0;
            rd_learnt_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                if (int'(rd_idx_i) < NUM_CLAUSES) begin
                    {rd_clause_o, rd_len_o, rd_learnt_o} <= slots[rd_idx_i];
                end else begin
                    {rd_clause_o, rd_len_o, rd_learnt_o} <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_cnt_o <= CW'(NUM_CLAUSES);
            full_o     <= 1'b0;
        end else begin
            free_cnt_o <= free_now;
            full_o     <= (free_now == '0);
        end
    end

endmodule

// File: tb/tb_clause_bank.sv
// Bench for clause_bank: directed table, hand sequences, random vs model.
module tb_clause_bank;
    import sat_pkg::*;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wr_i;
    logic [15:0] clause_i;
    logic [3:0]  clause_len_i;
    logic        learnt_valid_i;
    logic        learnt_ready_o;
    logic        rd_en_i;
    logic [2:0]  rd_idx_i;
    logic        rd_valid_o;
    logic [15:0] rd_clause_o;
    logic [3:0]  rd_len_o;
    logic        rd_learnt_o;
    logic        clear_learnt_i;
    logic [7:0]  learntc_insert_index_o;
    logic        insert_done_o;
    logic [2:0]  insert_slot_o;
    logic        evicted_o;
    logic [3:0]  free_cnt_o;
    logic        full_o;

    clause_bank dut (
        .clk                   (clk),
        .rst                   (rst),
        .wr_i                  (wr_i),
        .clause_i              (clause_i),
        .clause_len_i          (clause_len_i),
        .learnt_valid_i        (learnt_valid_i),
        .learnt_ready_o        (learnt_ready_o),
        .rd_en_i               (rd_en_i),
        .rd_idx_i              (rd_idx_i),
        .rd_valid_o            (rd_valid_o),
        .rd_clause_o           (rd_clause_o),
        .rd_len_o              (rd_len_o),
        .rd_learnt_o           (rd_learnt_o),
        .clear_learnt_i        (clear_learnt_i),
        .learntc_insert_index_o(learntc_insert_index_o),
        .insert_done_o         (insert_done_o),
        .insert_slot_o         (insert_slot_o),
        .evicted_o             (evicted_o),
        .free_cnt_o            (free_cnt_o),
        .full_o                (full_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_i           = '0;
        learnt_valid_i = 1'b0;
        clause_i       = '0;
        clause_len_i   = '0;
        rd_en_i        = 1'b0;
        rd_idx_i       = '0;
        clear_learnt_i = 1'b0;
    endtask

    // Reference model: plain arrays of slot contents plus victim pointer.
    int          m_len [N];
    logic [15:0] m_lit [N];
    bit          m_lrn [N];
    int          m_vptr;

    function automatic int m_pick();
        for (int i = 0; i < N; i++) if (m_len[i] == 0) return i;
        for (int k = 0; k < N; k++) begin
            if (m_lrn[(m_vptr + k) % N]) return (m_vptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int m_free();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_len[i] == 0) c++;
        return c;
    endfunction

    task automatic step(input logic [7:0] wr, input logic lv,
                        input logic [15:0] cl, input logic [3:0] len,
                        input logic re, input logic [2:0] ri);
        int p, f0;
        logic rdy, acc, ev;
        logic [15:0] e_lit;
        int e_len;
        bit e_lrn;
        wr_i = wr; learnt_valid_i = lv; clause_i = cl;
        clause_len_i = len; rd_en_i = re; rd_idx_i = ri;
        #1;
        p   = m_pick();
        rdy = (wr == 0) && (p >= 0);
        chk("rnd_ready", learnt_ready_o, rdy);
        chk("rnd_index", learntc_insert_index_o,
            (p >= 0) ? (32'd1 << p) : 32'd0);
        f0    = m_free();
        e_lit = m_lit[ri]; e_len = m_len[ri]; e_lrn = m_lrn[ri];
        acc   = lv && rdy && (len != 0);
        ev    = 1'b0;
        if (acc) ev = (m_len[p] != 0);
        for (int k = 0; k < N; k++) begin
            if (wr[k]) begin
                m_lit[k] = cl; m_len[k] = int'(len); m_lrn[k] = 1'b0;
            end
        end
        if (acc) begin
            m_lit[p] = cl; m_len[p] = int'(len); m_lrn[p] = 1'b1;
            if (ev) m_vptr = (p + 1) % N;
        end
        cyc();
        chk("rnd_done", insert_done_o, acc);
        chk("rnd_evicted", evicted_o, ev);
        if (acc) chk("rnd_slot", insert_slot_o, p);
        chk("rnd_rd_valid", rd_valid_o, re);
        if (re) begin
            chk("rnd_rd_clause", rd_clause_o, e_lit);
            chk("rnd_rd_len", rd_len_o, e_len);
            chk("rnd_rd_learnt", rd_learnt_o, e_lrn);
        end
        chk("rnd_free", free_cnt_o, f0);
        chk("rnd_full", full_o, f0 == 0);
    endtask

    typedef struct {
        logic [7:0] wr;
        logic       lv;
        logic [3:0] len;
        logic [7:0] idx;
        logic       rdy;
        logic       done;
        int         slot;
        logic       ev;
        int         free;
    } vec_t;

    vec_t tv [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        chk("reset_free", free_cnt_o, 8);
        chk("reset_full", full_o, 0);
        chk("reset_index", learntc_insert_index_o, 8'h01);
        chk("reset_rd_valid", rd_valid_o, 0);
        chk("reset_done", insert_done_o, 0);
        rst = 1'b0;

        tv[0]  = '{8'h01, 0, 4'd2, 8'h01, 0, 0, 0, 0, 8};
        tv[1]  = '{8'h02, 0, 4'd3, 8'h02, 0, 0, 0, 0, 7};
        tv[2]  = '{8'h04, 0, 4'd3, 8'h04, 0, 0, 0, 0, 6};
        tv[3]  = '{8'h08, 0, 4'd3, 8'h08, 0, 0, 0, 0, 5};
        tv[4]  = '{8'h10, 0, 4'd3, 8'h10, 0, 0, 0, 0, 4};
        tv[5]  = '{8'h00, 0, 4'd0, 8'h20, 1, 0, 0, 0, 3};
        tv[6]  = '{8'h00, 1, 4'd2, 8'h20, 1, 1, 5, 0, 3};
        tv[7]  = '{8'h00, 1, 4'd2, 8'h40, 1, 1, 6, 0, 2};
        tv[8]  = '{8'h00, 1, 4'd2, 8'h80, 1, 1, 7, 0, 1};
        tv[9]  = '{8'h00, 0, 4'd0, 8'h20, 1, 0, 0, 0, 0};
        tv[10] = '{8'h00, 1, 4'd2, 8'h20, 1, 1, 5, 1, 0};
        tv[11] = '{8'h00, 0, 4'd0, 8'h40, 1, 0, 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            wr_i = tv[i].wr; learnt_valid_i = tv[i].lv;
            clause_len_i = tv[i].len; clause_i = 16'h9A00 + 16'(i);
            #1;
            chk($sformatf("tv%0d_index", i), learntc_insert_index_o, tv[i].idx);
            chk($sformatf("tv%0d_ready", i), learnt_ready_o, tv[i].rdy);
            cyc();
            chk($sformatf("tv%0d_done", i), insert_done_o, tv[i].done);
            chk($sformatf("tv%0d_evicted", i), evicted_o, tv[i].ev);
            if (tv[i].done) chk($sformatf("tv%0d_slot", i), insert_slot_o, tv[i].slot);
            chk($sformatf("tv%0d_free", i), free_cnt_o, tv[i].free);
            chk($sformatf("tv%0d_full", i), full_o, tv[i].free == 0);
        end
        idle_inputs();

        // Learnt sweep: ready stays low for the whole pass.
        clear_learnt_i = 1'b1;
        cyc();
        clear_learnt_i = 1'b0;
        n = 0;
        while (!learnt_ready_o && n < 20) begin
            n++;
            cyc();
        end
        chk("clear_busy_cycles", n, 8);
        cyc();
        cyc();
        chk("clear_free", free_cnt_o, 3);
        chk("clear_full", full_o, 0);
        chk("clear_index", learntc_insert_index_o, 8'h20);
        rd_en_i = 1'b1; rd_idx_i = 3'd5;
        cyc();
        rd_en_i = 1'b1; rd_idx_i = 3'd1;
        chk("clear_rd5_valid", rd_valid_o, 1);
        chk("clear_rd5_len", rd_len_o, 0);
        chk("clear_rd5_learnt", rd_learnt_o, 0);
        cyc();
        rd_en_i = 1'b0;
        chk("rd1_clause", rd_clause_o, 16'h9A01);
        chk("rd1_len", rd_len_o, 3);
        chk("rd1_learnt", rd_learnt_o, 0);

        // Direct write and learnt request on the same cycle.
        wr_i = 8'h01; clause_i = {8{LIT_POS}}; clause_len_i = 4'd2;
        learnt_valid_i = 1'b1;
        #1;
        chk("prio_ready_low", learnt_ready_o, 0);
        cyc();
        chk("prio_no_done", insert_done_o, 0);
        wr_i = '0; clause_i = {8{LIT_NEG}}; clause_len_i = 4'd3;
        #1;
        chk("prio_ready_high", learnt_ready_o, 1);
        chk("prio_index", learntc_insert_index_o, 8'h20);
        cyc();
        learnt_valid_i = 1'b0;
        chk("prio_done", insert_done_o, 1);
        chk("prio_slot", insert_slot_o, 5);
        chk("prio_evicted", evicted_o, 0);
        rd_en_i = 1'b1; rd_idx_i = 3'd0;
        cyc();
        rd_en_i = 1'b0;
        chk("prio_rd0_clause", rd_clause_o, 16'h5555);
        chk("prio_rd0_len", rd_len_o, 2);
        chk("prio_rd0_learnt", rd_learnt_o, 0);

        // Fill every slot with originals.
        clause_i = 16'h0F0F;
        wr_i = 8'h20; clause_len_i = 4'd2; cyc();
        wr_i = 8'h40; clause_len_i = 4'd4; cyc();
        wr_i = 8'h80; clause_len_i = 4'd4; cyc();
        wr_i = '0;
        cyc();
        cyc();
        chk("full_flag", full_o, 1);
        chk("full_free", free_cnt_o, 0);
        chk("full_index", learntc_insert_index_o, 8'h00);
        chk("full_ready", learnt_ready_o, 0);
        learnt_valid_i = 1'b1; clause_len_i = 4'd3;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("full_no_done%0d", i), insert_done_o, 0);
        end
        idle_inputs();

        // Reset in the middle of a sweep.
        clear_learnt_i = 1'b1;
        cyc();
        clear_learnt_i = 1'b0;
        rd_en_i = 1'b1; rd_idx_i = 3'd6;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_valid", rd_valid_o, 0);
        chk("mid_rst_rd_len", rd_len_o, 0);
        chk("mid_rst_rd_clause", rd_clause_o, 0);
        chk("mid_rst_slot", insert_slot_o, 0);
        chk("mid_rst_done", insert_done_o, 0);
        chk("mid_rst_evicted", evicted_o, 0);
        chk("mid_rst_free", free_cnt_o, 8);
        chk("mid_rst_full", full_o, 0);
        idle_inputs();
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_free", free_cnt_o, 8);
        chk("post_rst_ready", learnt_ready_o, 1);
        chk("post_rst_index0", learntc_insert_index_o[0], 1);

        for (int i = 0; i < N; i++) begin
            m_len[i] = 0; m_lit[i] = '0; m_lrn[i] = 1'b0;
        end
        m_vptr = 0;
        for (int t = 0; t < 400; t++) begin
            logic [7:0] w;
            logic [3:0] l;
            w = ($urandom % 6 == 0) ? 8'($urandom) : 8'h00;
            l = ($urandom % 5 == 0) ? 4'd0 : 4'(1 + $urandom % 15);
            step(w, 1'($urandom), 16'($urandom), l,
                 1'($urandom), 3'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
